multiplexer_nsrc_hs: RTL and testbench

//  Registered N-source bus multiplexer with valid/ready handshake on every source
//  and on the output. Parametrised successor of the fixed 4-source one-hot mux.

---
 rtl/multiplexer_nsrc_hs.sv | 109 ++++++++++
 tb/tb_multiplexer_nsrc_hs.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiplexer_nsrc_hs.sv
// multiplexer_nsrc_hs
//   Registered N-source bus multiplexer with a valid/ready handshake on every
//   source and on the output. The output register is a one-entry buffer. When
//   it is empty, or is drained in the same cycle, it can take one source word.
//   MODE 0 takes the source picked by a one-hot sel and flags illegal selects.
//   MODE 1 arbitrates round-robin among the sources enabled in sel.
//
// Ports
//   clk        single clock, all state on posedge
//   rst        asynchronous reset, active low
//   sel        MODE0: one-hot source select; MODE1: per-source enable mask
//   src_data   flattened source words, source i at [i*BUS_WIDTH +: BUS_WIDTH]
//   src_valid  source i offers a word
//   src_ready  source i word taken this cycle (combinational, at most one bit)
//   out_data   registered output word
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer takes out_data this cycle
//   out_src    index of the source that produced out_data
//   sel_err    registered one-cycle pulse for an illegal sel in MODE0
module multiplexer_nsrc_hs #(
  parameter int  BUS_WIDTH = 8,
  parameter int  NUM_SRC   = 4,
  parameter int  MODE      = 0,
  localparam int IDX_W     = $clog2(NUM_SRC)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           sel,
  input  logic [NUM_SRC*BUS_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [NUM_SRC-1:0]           src_ready,
  output logic [BUS_WIDTH-1:0]         out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IDX_W-1:0]             out_src,
  output logic                         sel_err
);

  logic                 load;
  logic                 sel_onehot;
  logic                 grant;
  logic [IDX_W-1:0]     grant_idx;
  logic [NUM_SRC-1:0]   req;
  logic [BUS_WIDTH-1:0] grant_word;
  logic [IDX_W-1:0]     rr_ptr;
  int                   cand;

  // The buffer can accept a word when empty or when its word leaves this cycle.
  assign load       = !out_valid || out_ready;
  assign sel_onehot = $onehot(sel);

  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    req       = '0;
    cand      = 0;
    if (MODE == 0) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (sel[i]) grant_idx = IDX_W'(i);
      end
      grant = sel_onehot && src_valid[grant_idx] && load;
    end else begin
      req = src_valid & sel;
      // Walk the candidates from farthest to nearest so that the candidate
      // closest to rr_ptr is the one that remains after the loop.
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
        cand = int'(rr_ptr) + k;
        if (cand >= NUM_SRC) cand = cand - NUM_SRC;
        if (req[cand]) begin
          grant     = 1'b1;
          grant_idx = IDX_W'(cand);
        end
      end
      grant = grant && load;
    end
  end

  assign grant_word = src_data[grant_idx*BUS_WIDTH +: BUS_WIDTH];

  // While rst is low the handshake is blocked so that no source loses a word.
  always_comb begin
    src_ready = '0;
    if (rst && grant) src_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_src   <= '0;
      sel_err   <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      if (grant) begin
        out_data  <= grant_word;
        out_src   <= grant_idx;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // An illegal select is reported whether or not any source is waiting.
      sel_err <= (MODE == 0) && !sel_onehot;
      if ((MODE != 0) && grant) begin
        rr_ptr <= (int'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multiplexer_nsrc_hs.sv
module tb_multiplexer_nsrc_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sel;
  logic [3:0]  src_valid;
  logic [7:0]  sd [4];
  logic [31:0] src_data;
  logic        out_ready;

  logic [3:0]  rdy0, rdy1;
  logic [7:0]  od0, od1;
  logic        ov0, ov1;
  logic [1:0]  os0, os1;
  logic        err0, err1;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic       mv0, mv1;
  int         rr1;
  logic [9:0] q0[$];
  logic [9:0] q1[$];

  always #5 clk = ~clk;

  assign src_data = {sd[3], sd[2], sd[1], sd[0]};

  multiplexer_nsrc_hs #(.BUS_WIDTH(8), .NUM_SRC(4), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .sel(sel), .src_data(src_data), .src_valid(src_valid),
    .src_ready(rdy0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
    .out_src(os0), .sel_err(err0)
  );

  multiplexer_nsrc_hs #(.BUS_WIDTH(8), .NUM_SRC(4), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .sel(sel), .src_data(src_data), .src_valid(src_valid),
    .src_ready(rdy1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
    .out_src(os1), .sel_err(err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle. Inputs are set by the caller just after a posedge; the
  // handshake is predicted and checked at the negedge, and the registered
  // outputs are checked just after the next posedge.
  task automatic cycle();
    logic [3:0] g0, g1;
    logic       onehot, ld0, ld1;
    int         gi0, gi1, idx;
    logic [9:0] e;
    @(negedge clk);
    onehot = ($countones(sel) == 1);
    ld0 = !mv0 || out_ready;
    ld1 = !mv1 || out_ready;
    g0 = 4'b0; gi0 = -1;
    if (onehot && ld0) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i] && src_valid[i]) begin
          g0[i] = 1'b1;
          gi0 = i;
        end
      end
    end
    g1 = 4'b0; gi1 = -1;
    if (ld1) begin
      for (int k = 0; k < 4; k++) begin
        idx = (rr1 + k) % 4;
        if (gi1 < 0 && sel[idx] && src_valid[idx]) begin
          gi1 = idx;
          g1[idx] = 1'b1;
        end
      end
    end
    check("rdy_m0", rdy0, g0);
    check("rdy_m1", rdy1, g1);
    if (mv0 && out_ready) begin
      check("sb_m0_avail", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("sb_m0_word", {os0, od0}, e);
      end
    end
    if (mv1 && out_ready) begin
      check("sb_m1_avail", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("sb_m1_word", {os1, od1}, e);
      end
    end
    if (gi0 >= 0) q0.push_back({2'(gi0), sd[gi0]});
    if (gi1 >= 0) q1.push_back({2'(gi1), sd[gi1]});
    @(posedge clk);
    #1;
    mv0 = (gi0 >= 0) ? 1'b1 : (out_ready ? 1'b0 : mv0);
    mv1 = (gi1 >= 0) ? 1'b1 : (out_ready ? 1'b0 : mv1);
    if (gi1 >= 0) rr1 = (gi1 + 1) % 4;
    check("valid_m0", ov0, mv0);
    check("valid_m1", ov1, mv1);
    check("err_m0", err0, !onehot);
    check("err_m1", err1, 0);
  endtask

  task automatic do_reset_check();
    rst = 1'b0;
    #1;
    check("rst_valid_m0", ov0, 0);
    check("rst_data_m0", od0, 0);
    check("rst_src_m0", os0, 0);
    check("rst_err_m0", err0, 0);
    check("rst_rdy_m0", rdy0, 0);
    check("rst_valid_m1", ov1, 0);
    check("rst_data_m1", od1, 0);
    check("rst_src_m1", os1, 0);
    check("rst_rdy_m1", rdy1, 0);
    q0.delete();
    q1.delete();
    mv0 = 1'b0;
    mv1 = 1'b0;
    rr1 = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    sel = 4'b0;
    src_valid = 4'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) sd[i] = 8'h00;
    mv0 = 1'b0; mv1 = 1'b0; rr1 = 0;
    #2;
    do_reset_check();

    // one-hot select of source 2
    sd[0] = 8'h10; sd[1] = 8'h21; sd[2] = 8'hA5; sd[3] = 8'h3C;
    sel = 4'b0100; src_valid = 4'b1111; out_ready = 1'b1;
    cycle();
    check("t2_data", od0, 8'hA5);
    check("t2_src", os0, 2);
    check("t2_valid", ov0, 1);
    cycle();
    cycle();

    // illegal selects
    sel = 4'b0110;
    cycle();
    check("t3_err", err0, 1);
    check("t3_drained", ov0, 0);
    sel = 4'b0100;
    cycle();
    check("t3_err_clear", err0, 0);
    sel = 4'b0000;
    cycle();
    check("t3_err_zero", err0, 1);
    sel = 4'b0100;
    cycle();

    // backpressure
    sd[2] = 8'h11;
    cycle();
    check("t4_load", od0, 8'h11);
    out_ready = 1'b0;
    sd[2] = 8'h22;
    repeat (5) begin
      cycle();
      check("t4_hold", od0, 8'h11);
    end
    out_ready = 1'b1;
    cycle();
    check("t4_next", od0, 8'h22);
    out_ready = 1'b0;
    sd[2] = 8'h33;
    cycle();
    check("t4_held", od0, 8'h22);

    // reset mid-stream with a held word
    check("t1_pre_valid", ov0, 1);
    do_reset_check();

    // round-robin
    for (int i = 0; i < 4; i++) sd[i] = 8'h50 + 8'(i);
    sel = 4'b1111; src_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("t5_rr_all", os1, i % 4);
    end
    sel = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t5_rr_1010", os1, (i % 2 == 1) ? 3 : 1);
    end

    // round-robin wrap from pointer 3
    sel = 4'b0100;
    cycle();
    check("t6_pre", os1, 2);
    sel = 4'b1001; src_valid = 4'b1001;
    cycle();
    check("t6_g3", os1, 3);
    cycle();
    check("t6_g0", os1, 0);
    sel = 4'b1111; src_valid = 4'b1111;
    cycle();
    check("t6_ptr", os1, 1);

    // drain
    src_valid = 4'b0;
    repeat (2) cycle();
    check("sb_m0_left", q0.size(), 0);
    check("sb_m1_left", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
